// File: rtl/tpu_output_writeback.sv
// ---------------------------------------------------------------------------
// tpu_output_writeback
// Final datapath stage: takes signed 32-bit accumulator words from the PE-array
// drain, adds a per-word bias, requantizes (multiply, round-half-up arithmetic
// shift, optional ReLU, int8 saturation) and writes the sign-extended int8
// result to consecutive linear addresses of the banked output SRAM.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start_i              one-cycle pulse, latches configuration, starts a layer
//   num_words_i          results to write in this layer (sampled on start_i)
//   scale_i, shift_i     unsigned requant multiplier / right shift (on start_i)
//   relu_en_i            clamp negative results to zero (on start_i)
//   acc_valid_i/_ready_o accumulator handshake
//   acc_data_i, bias_i   signed accumulator and bias, qualified by acc_valid_i
//   out_cs_o             one-hot bank chip select
//   out_web_o            active-low write enable
//   out_addr_o, out_di_o in-bank word address and write data
//   finish_o             level, high once every write of the layer is issued
// ---------------------------------------------------------------------------
module tpu_output_writeback #(
   parameter int N_BANKS = 6,
   parameter int BANK_AW = 15,
   parameter int CNT_W   = 18,
   parameter int ACC_W   = 32,
   parameter int SCALE_W = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start_i,
   input  logic [CNT_W-1:0]          num_words_i,
   input  logic [SCALE_W-1:0]        scale_i,
   input  logic [4:0]                shift_i,
   input  logic                      relu_en_i,
   input  logic                      acc_valid_i,
   output logic                      acc_ready_o,
   input  logic signed [ACC_W-1:0]   acc_data_i,
   input  logic signed [ACC_W-1:0]   bias_i,
   output logic [N_BANKS-1:0]        out_cs_o,
   output logic                      out_web_o,
   output logic [BANK_AW-1:0]        out_addr_o,
   output logic [15:0]               out_di_o,
   output logic                      finish_o
);

   localparam int PROD_W = ACC_W + SCALE_W + 1;
   // One guard bit so adding the rounding constant can never wrap.
   localparam int RND_W  = PROD_W + 1;
   localparam int BSEL_W = CNT_W - BANK_AW;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [CNT_W-1:0]           r_num_words;
   logic [SCALE_W-1:0]         r_scale;
   logic [4:0]                 r_shift;
   logic                       r_relu;
   logic [CNT_W-1:0]           r_acc_cnt;
   logic [CNT_W-1:0]           r_wr_idx;
   logic                       r_vld_p1, r_vld_p2, r_vld_p3;
   logic signed [ACC_W-1:0]    r_sum_p1;
   logic signed [PROD_W-1:0]   r_prod_p2;
   logic signed [7:0]          r_q_p3;

   logic                       w_start_ok;
   logic                       w_ready;
   logic                       w_xfer;
   logic                       w_last_acc;
   logic signed [ACC_W:0]      w_sum;

   // Saturate a 33-bit sum back to signed 32-bit.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
      if (x[ACC_W] != x[ACC_W-1])
         return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return x[ACC_W-1:0];
   endfunction

   // Add half an LSB of the result, then arithmetic shift: round half up (+inf).
   function automatic logic signed [RND_W-1:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                            input logic [4:0] sh);
      logic signed [RND_W-1:0] ext;
      logic signed [RND_W-1:0] half;
      logic signed [RND_W-1:0] tot;
      ext  = $signed({p[PROD_W-1], p});
      half = (sh == 5'd0) ? '0 : (RND_W'(1) << (sh - 5'd1));
      tot  = ext + half;
      return tot >>> sh;
   endfunction

   // Optional ReLU followed by clamp to the int8 range.
   function automatic logic signed [7:0] sat_int8(input logic signed [RND_W-1:0] r,
                                                  input logic relu);
      if (relu && r[RND_W-1])           return 8'sd0;
      if (r > RND_W'(127))              return 8'sd127;
      if (r < RND_W'(-128))             return -8'sd128;
      return r[7:0];
   endfunction

   // Indices past the last bank decode to no chip select, dropping the write.
   function automatic logic [N_BANKS-1:0] bank_sel(input logic [CNT_W-1:0] idx);
      logic [N_BANKS-1:0] sel;
      sel = '0;
      for (int k = 0; k < N_BANKS; k++)
         if (idx[CNT_W-1:BANK_AW] == BSEL_W'(k)) sel[k] = 1'b1;
      return sel;
   endfunction

   assign w_start_ok  = start_i && ((r_state == IDLE) || (r_state == DONE));
   assign w_ready     = (r_state == RUN) && (r_acc_cnt < r_num_words);
   assign w_xfer      = acc_valid_i && w_ready;
   assign w_last_acc  = w_xfer && ((r_acc_cnt + CNT_W'(1)) == r_num_words);
   assign w_sum       = $signed({acc_data_i[ACC_W-1], acc_data_i}) +
                        $signed({bias_i[ACC_W-1], bias_i});
   assign acc_ready_o = w_ready;
   assign finish_o    = (r_state == DONE);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE, DONE: if (start_i) w_state_nxt = (num_words_i == '0) ? DONE : RUN;
         RUN:        if (w_last_acc) w_state_nxt = DRAIN;
         DRAIN:      if (!(r_vld_p1 || r_vld_p2 || r_vld_p3)) w_state_nxt = DONE;
         default:    w_state_nxt = IDLE;
      endcase
   end

   // Control, valid flags and registered SRAM outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_num_words <= '0;
         r_scale     <= '0;
         r_shift     <= '0;
         r_relu      <= 1'b0;
         r_acc_cnt   <= '0;
         r_wr_idx    <= '0;
         r_vld_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_vld_p3    <= 1'b0;
         out_cs_o    <= '0;
         out_web_o   <= 1'b1;
         out_addr_o  <= '0;
         out_di_o    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_ok) begin
            r_num_words <= num_words_i;
            r_scale     <= scale_i;
            r_shift     <= shift_i;
            r_relu      <= relu_en_i;
            r_acc_cnt   <= '0;
            r_wr_idx    <= '0;
         end else begin
            if (w_xfer)   r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            if (r_vld_p3) r_wr_idx  <= r_wr_idx + CNT_W'(1);
         end
         r_vld_p1 <= w_xfer;
         r_vld_p2 <= r_vld_p1;
         r_vld_p3 <= r_vld_p2;
         // ---- write stage: S3 result to SRAM port ----
         if (r_vld_p3) begin
            out_cs_o   <= bank_sel(r_wr_idx);
            out_web_o  <= 1'b0;
            out_addr_o <= r_wr_idx[BANK_AW-1:0];
            out_di_o   <= {{8{r_q_p3[7]}}, r_q_p3};
         end else begin
            out_cs_o   <= '0;
            out_web_o  <= 1'b1;
         end
      end
   end

   // Datapath registers carry no reset; their valid flags qualify them.
   always_ff @(posedge clk) begin
      // ---- S1: bias add with 32-bit saturation ----
      r_sum_p1  <= sat_acc(w_sum);
      // ---- S2: unsigned scale multiply ----
      r_prod_p2 <= r_sum_p1 * $signed({1'b0, r_scale});
      // ---- S3: round, shift, ReLU, int8 clamp ----
      r_q_p3    <= sat_int8(round_shift(r_prod_p2, r_shift), r_relu);
   end

endmodule
